// File: rtl/uart_rx_fifo_if.sv
// CPU-side view of the UART receiver: FIFO head, pop strobe, status and sticky error flags.
// Handshake: data is the FIFO head and is meaningful only while empty=0; a read is a pop
// request taken on the rising clk edge only when empty=0, otherwise it is ignored.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS       = 8,
  parameter int FIFO_DEPTH_BITS = 3
) ();
  logic [DATA_BITS-1:0]     data;
  logic                     read;
  logic                     empty;
  logic                     full;
  logic [FIFO_DEPTH_BITS:0] count;
  logic                     interrupt;
  logic                     interrupt_clear;
  logic                     parity_error;
  logic                     framing_error;
  logic                     overrun;

  modport master (
    input  data, empty, full, count, interrupt, parity_error, framing_error, overrun,
    output read, interrupt_clear
  );

  modport slave (
    output data, empty, full, count, interrupt, parity_error, framing_error, overrun,
    input  read, interrupt_clear
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable width/parity, first-word-fall-through FIFO and sticky
// parity/framing/overrun flags behind a level interrupt.
module uart_rx_fifo #(
  parameter int CLOCK_DIV          = 8,
  parameter int CLOCK_COUNTER_BITS = 4,
  parameter int DATA_BITS          = 8,
  parameter int PARITY             = 0,
  parameter int FIFO_DEPTH_BITS    = 3
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             rx,
  uart_rx_fifo_if.slave    bus,
  output logic [2:0]       dbg_state_o
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int CW    = FIFO_DEPTH_BITS + 1;
  localparam int PW    = FIFO_DEPTH_BITS;
  localparam int TW    = CLOCK_COUNTER_BITS;

  localparam logic [TW-1:0] HALF_C   = TW'(CLOCK_DIV / 2 - 1);
  localparam logic [TW-1:0] BIT_C    = TW'(CLOCK_DIV - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [3:0]    LAST_IDX = 4'(DATA_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [PW-1:0] P_ONE    = PW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rxs_q;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pmis_q, pmis_d;
  logic                 push_req, frm_set, par_set, ovr_set;
  logic                 push, pop;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 int_q, perr_q, ferr_q, ovr_q;
  logic                 int_set;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      pmis_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      pmis_q    <= pmis_d;
    end
  end

  // Bit timer runs freely inside a frame; every sample point reloads it to zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + T_ONE;
    idx_d    = idx_q;
    shift_d  = shift_q;
    pmis_d   = pmis_q;
    push_req = 1'b0;
    frm_set  = 1'b0;
    par_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_C) begin
          cnt_d = '0;
          if (!rxs_q) begin
            state_d = S_DATA;
            idx_d   = '0;
            pmis_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_C) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 4'd1;
          if (idx_q == LAST_IDX) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (cnt_q == BIT_C) begin
          cnt_d   = '0;
          pmis_d  = (PARITY == 1) ? ~(^shift_q ^ rxs_q) : (^shift_q ^ rxs_q);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_C) begin
          cnt_d = '0;
          if (!rxs_q) begin
            frm_set = 1'b1;
            state_d = S_BREAK;
          end else begin
            state_d = S_IDLE;
            if (pmis_q) par_set  = 1'b1;
            else        push_req = 1'b1;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot the incoming frame needs.
  always_comb begin
    pop     = bus.read && (count_q != '0);
    push    = push_req && ((count_q != DEPTH_C) || pop);
    ovr_set = push_req && (count_q == DEPTH_C) && !pop;
    int_set = push || frm_set || par_set || ovr_set;
    case ({push, pop})
      2'b10:   count_d = count_q + C_ONE;
      2'b01:   count_d = count_q - C_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      int_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + P_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + P_ONE;
      count_q <= count_d;
      // Set events take priority over a simultaneous software clear.
      int_q   <= int_set ? 1'b1 : (bus.interrupt_clear ? 1'b0 : int_q);
      perr_q  <= par_set ? 1'b1 : (bus.interrupt_clear ? 1'b0 : perr_q);
      ferr_q  <= frm_set ? 1'b1 : (bus.interrupt_clear ? 1'b0 : ferr_q);
      ovr_q   <= ovr_set ? 1'b1 : (bus.interrupt_clear ? 1'b0 : ovr_q);
    end
  end

  assign bus.empty         = (count_q == '0);
  assign bus.full          = (count_q == DEPTH_C);
  assign bus.count         = count_q;
  assign bus.data          = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign bus.interrupt     = int_q;
  assign bus.parity_error  = perr_q;
  assign bus.framing_error = ferr_q;
  assign bus.overrun       = ovr_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: one 8N1 receiver and one 7-bit even-parity receiver, driven by
// a serial frame task, with pops checked against expected queues by per-instance monitors.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       nreset;
  logic       rx0, rx1;
  logic [2:0] dbg0, dbg1;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH_BITS(3)) bus0 ();
  uart_rx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH_BITS(3)) bus1 ();

  uart_rx_fifo #(
    .CLOCK_DIV(8), .CLOCK_COUNTER_BITS(4), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH_BITS(3)
  ) dut0 (
    .clk(clk), .nreset(nreset), .rx(rx0), .bus(bus0), .dbg_state_o(dbg0)
  );

  uart_rx_fifo #(
    .CLOCK_DIV(8), .CLOCK_COUNTER_BITS(4), .DATA_BITS(7), .PARITY(2), .FIFO_DEPTH_BITS(3)
  ) dut1 (
    .clk(clk), .nreset(nreset), .rx(rx1), .bus(bus1), .dbg_state_o(dbg1)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp0_q[$];
  logic [8:0] exp1_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: a pop is seen when read is high and the FIFO is non-empty mid-cycle.
  always @(negedge clk) begin
    logic [8:0] e;
    #2;
    if (bus0.read && !bus0.empty) begin
      n_checks++;
      if (exp0_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop0_unexpected: got 0x%0h, expected nothing", bus0.data);
      end else begin
        e = exp0_q.pop_front();
        if (9'(bus0.data) !== e) begin
          n_fail++;
          $display("FAIL pop0_data: got 0x%0h, expected 0x%0h", bus0.data, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    #2;
    if (bus1.read && !bus1.empty) begin
      n_checks++;
      if (exp1_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop1_unexpected: got 0x%0h, expected nothing", bus1.data);
      end else begin
        e = exp1_q.pop_front();
        if (9'(bus1.data) !== e) begin
          n_fail++;
          $display("FAIL pop1_data: got 0x%0h, expected 0x%0h", bus1.data, e);
        end
      end
    end
  end

  task automatic drive_rx(input int which, input logic v);
    if (which == 0) rx0 = v;
    else            rx1 = v;
  endtask

  // One frame, 8 clk per bit; starts on the next falling clk edge.
  task automatic send_frame(input int which, input logic [8:0] d, input int nbits,
                            input int par_mode, input bit flip, input logic stop_v);
    logic [11:0] bits;
    int          nb;
    bits = '0;
    nb   = 0;
    bits[nb] = 1'b0;
    nb++;
    for (int i = 0; i < nbits; i++) begin
      bits[nb] = d[i];
      nb++;
    end
    if (par_mode != 0) begin
      bits[nb] = ((par_mode == 2) ? ^d : ~^d) ^ flip;
      nb++;
    end
    bits[nb] = stop_v;
    nb++;
    @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      drive_rx(which, bits[i]);
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic pop(input int which);
    @(negedge clk);
    if (which == 0) bus0.read = 1'b1;
    else            bus1.read = 1'b1;
    @(negedge clk);
    if (which == 0) bus0.read = 1'b0;
    else            bus1.read = 1'b0;
  endtask

  task automatic clear_irq(input int which);
    @(negedge clk);
    if (which == 0) bus0.interrupt_clear = 1'b1;
    else            bus1.interrupt_clear = 1'b1;
    @(negedge clk);
    if (which == 0) bus0.interrupt_clear = 1'b0;
    else            bus1.interrupt_clear = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nreset = 1'b0;
    rx0 = 1'b1;
    rx1 = 1'b1;
    bus0.read = 1'b0;
    bus0.interrupt_clear = 1'b0;
    bus1.read = 1'b0;
    bus1.interrupt_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_empty", 32'(bus0.empty), 32'd1);
    chk("rst_full", 32'(bus0.full), 32'd0);
    chk("rst_count", 32'(bus0.count), 32'd0);
    chk("rst_data", 32'(bus0.data), 32'd0);
    chk("rst_irq", 32'(bus0.interrupt), 32'd0);
    chk("rst_flags", 32'({bus0.parity_error, bus0.framing_error, bus0.overrun}), 32'd0);
    chk("rst_empty1", 32'(bus1.empty), 32'd1);
    nreset = 1'b1;
    repeat (4) @(negedge clk);

    // Single 8N1 frame
    exp0_q.push_back(9'h5A);
    send_frame(0, 9'h5A, 8, 0, 1'b0, 1'b1);
    chk("dflt_count", 32'(bus0.count), 32'd1);
    chk("dflt_data", 32'(bus0.data), 32'h5A);
    chk("dflt_empty", 32'(bus0.empty), 32'd0);
    chk("dflt_irq", 32'(bus0.interrupt), 32'd1);
    pop(0);
    chk("dflt_empty_after", 32'(bus0.empty), 32'd1);
    chk("dflt_data_after", 32'(bus0.data), 32'd0);
    clear_irq(0);
    chk("dflt_irq_clr", 32'(bus0.interrupt), 32'd0);

    // Start-bit glitch
    @(negedge clk);
    rx0 = 1'b0;
    repeat (3) @(negedge clk);
    rx0 = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_state", 32'(dbg0), 32'd0);
    chk("glitch_count", 32'(bus0.count), 32'd0);
    chk("glitch_irq", 32'(bus0.interrupt), 32'd0);
    chk("glitch_flags", 32'({bus0.parity_error, bus0.framing_error, bus0.overrun}), 32'd0);

    // Overrun: nine frames into eight slots
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp0_q.push_back(9'(i));
      send_frame(0, 9'(i), 8, 0, 1'b0, 1'b1);
    end
    chk("ovr_count", 32'(bus0.count), 32'd8);
    chk("ovr_full", 32'(bus0.full), 32'd1);
    chk("ovr_flag", 32'(bus0.overrun), 32'd1);
    chk("ovr_irq", 32'(bus0.interrupt), 32'd1);
    for (int i = 0; i < 8; i++) pop(0);
    chk("ovr_drained", 32'(bus0.empty), 32'd1);
    chk("ovr_sticky", 32'(bus0.overrun), 32'd1);
    clear_irq(0);
    chk("ovr_clr", 32'({bus0.interrupt, bus0.overrun}), 32'd0);

    // Full FIFO with a pop on the push edge of 0x77
    for (int i = 0; i < 8; i++) begin
      exp0_q.push_back(9'(8'h10 + i));
      send_frame(0, 9'(8'h10 + i), 8, 0, 1'b0, 1'b1);
    end
    chk("bnd_full_pre", 32'(bus0.full), 32'd1);
    exp0_q.push_back(9'h77);
    fork
      send_frame(0, 9'h77, 8, 0, 1'b0, 1'b1);
      begin
        @(negedge clk);
        repeat (78) @(negedge clk);
        bus0.read = 1'b1;
        @(negedge clk);
        bus0.read = 1'b0;
      end
    join
    chk("bnd_count", 32'(bus0.count), 32'd8);
    chk("bnd_overrun", 32'(bus0.overrun), 32'd0);
    for (int i = 0; i < 8; i++) pop(0);
    chk("bnd_drained", 32'(bus0.empty), 32'd1);
    clear_irq(0);

    // Framing error followed by a line break, then a clean frame
    send_frame(0, 9'hA5, 8, 0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    rx0 = 1'b1;
    repeat (8) @(negedge clk);
    chk("frm_flag", 32'(bus0.framing_error), 32'd1);
    chk("frm_count", 32'(bus0.count), 32'd0);
    chk("frm_par", 32'(bus0.parity_error), 32'd0);
    chk("frm_irq", 32'(bus0.interrupt), 32'd1);
    chk("frm_state", 32'(dbg0), 32'd0);
    exp0_q.push_back(9'h3C);
    send_frame(0, 9'h3C, 8, 0, 1'b0, 1'b1);
    chk("frm_next_count", 32'(bus0.count), 32'd1);
    chk("frm_next_data", 32'(bus0.data), 32'h3C);
    pop(0);
    clear_irq(0);
    chk("frm_clr", 32'(bus0.framing_error), 32'd0);

    // 7E1: good parity stored, inverted parity dropped
    exp1_q.push_back(9'h35);
    send_frame(1, 9'h35, 7, 2, 1'b0, 1'b1);
    chk("par_good_count", 32'(bus1.count), 32'd1);
    chk("par_good_data", 32'(bus1.data), 32'h35);
    chk("par_good_flag", 32'(bus1.parity_error), 32'd0);
    send_frame(1, 9'h35, 7, 2, 1'b1, 1'b1);
    chk("par_bad_flag", 32'(bus1.parity_error), 32'd1);
    chk("par_bad_count", 32'(bus1.count), 32'd1);
    chk("par_bad_frm", 32'(bus1.framing_error), 32'd0);
    pop(1);
    chk("par_drained", 32'(bus1.empty), 32'd1);
    clear_irq(1);
    chk("par_clr", 32'({bus1.interrupt, bus1.parity_error}), 32'd0);

    // Reset in the middle of a frame with one entry held
    exp0_q.push_back(9'h42);
    send_frame(0, 9'h42, 8, 0, 1'b0, 1'b1);
    chk("mrst_pre_count", 32'(bus0.count), 32'd1);
    @(negedge clk);
    rx0 = 1'b0;
    repeat (20) @(negedge clk);
    nreset = 1'b0;
    rx0 = 1'b1;
    #2;
    exp0_q.delete();
    chk("mrst_count", 32'(bus0.count), 32'd0);
    chk("mrst_empty", 32'(bus0.empty), 32'd1);
    chk("mrst_data", 32'(bus0.data), 32'd0);
    chk("mrst_irq", 32'(bus0.interrupt), 32'd0);
    chk("mrst_state", 32'(dbg0), 32'd0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (20) @(negedge clk);
    chk("mrst_idle", 32'(dbg0), 32'd0);
    chk("mrst_still_empty", 32'(bus0.count), 32'd0);
    exp0_q.push_back(9'hC3);
    send_frame(0, 9'hC3, 8, 0, 1'b0, 1'b1);
    chk("mrst_next_count", 32'(bus0.count), 32'd1);
    chk("mrst_next_data", 32'(bus0.data), 32'hC3);
    pop(0);

    repeat (4) @(negedge clk);
    chk("exp0_left", 32'(exp0_q.size()), 32'd0);
    chk("exp1_left", 32'(exp1_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor to the single-byte UART receiver (uart1rx). Adds configurable data width and parity, a first-word-fall-through receive FIFO, and sticky parity, framing and overrun error flags. It sits between the rx pad and the CPU bus glue in main. The interrupt is level-held until cleared by software.

Parameters:
CLOCK_DIV, 8, clk cycles per UART bit (>=4, even)
CLOCK_COUNTER_BITS, 4, width of bit-timing counter (must hold CLOCK_DIV-1)
DATA_BITS, 8, data bits per frame (5..9), LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
FIFO_DEPTH_BITS, 3, FIFO depth = 2**FIFO_DEPTH_BITS entries

Ports:
clk  input  1  system clock
nreset  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
data  output  DATA_BITS  FIFO head (first-word fall-through); 0 when empty
read  input  1  pop head on rising clk when !empty; ignored when empty
empty  output  1  FIFO holds no entries
full  output  1  FIFO holds 2**FIFO_DEPTH_BITS entries
count  output  FIFO_DEPTH_BITS+1  number of entries held
interrupt  output  1  set on push or any error; held until cleared
interrupt_clear  input  1  clears interrupt and all error flags
parity_error  output  1  sticky: frame dropped due to parity mismatch
framing_error  output  1  sticky: frame dropped due to stop bit = 0
overrun  output  1  sticky: frame dropped because FIFO full

Behaviour:
- Reset (nreset=0, async): FSM=IDLE; counters, pointers and flags cleared; rx synchroniser preset to 1; empty=1; full=0; count=0; data=0; interrupt and all error flags = 0.
- rx passes a 2-flop synchroniser (rxs); all decisions use rxs.
- IDLE: rxs=0 -> START, counter=0.
- START: at counter=CLOCK_DIV/2-1, sample rxs. If 0 -> DATA, counter=0, bit index=0. If 1 -> glitch, return to IDLE with no flag.
- DATA: sample every CLOCK_DIV cycles (mid-bit), shifting LSB first. After DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
- PARITY: one sample. Odd mode requires an odd total of ones across data and parity bits; even mode requires an even total. Record the mismatch.
- STOP: one sample.
  - rxs=1 and no parity mismatch: push if !full, else set overrun and drop.
  - rxs=1 with parity mismatch: set parity_error, drop.
  - rxs=0: set framing_error, drop (framing takes precedence over parity), go to BREAK.
  - All rxs=1 cases return to IDLE.
- BREAK: wait for rxs=1, then IDLE. No new start bit is detected meanwhile.
- Push/pop timing: push occurs on the stop-sample clock edge. The entry is visible (empty=0, count+1, data valid) the following cycle.
- Simultaneous read and push:
  - Both succeed; count unchanged.
  - When full, the pop frees a slot: no overrun, the frame is stored.
  - When empty, the push succeeds and the read is ignored.
- Pointers wrap modulo 2**FIFO_DEPTH_BITS. full is count==2**FIFO_DEPTH_BITS; empty is count==0.
- interrupt sets on any push or error-flag set. interrupt_clear clears interrupt and all three error flags. If a set event and interrupt_clear occur in the same cycle, the set wins.
- Error flags never block reception. The FIFO is not flushed by errors or by interrupt_clear.
- Reset mid-frame aborts the frame; nothing is pushed and no flag is set.
- Frame length = 1 + DATA_BITS + (PARITY!=0) + 1 bits. Stop sample occurs about (frame_bits-0.5)*CLOCK_DIV + 2 cycles after the falling edge on rx.

Test Plan:
- Defaults. uart1tx (CLOCK_DIV=8) sends 0x5A -> within 85 clk of start: count=1, data=0x5A, empty=0, interrupt=1. Assert read for one cycle -> empty=1, data=0. Pulse interrupt_clear -> interrupt=0.
- Glitch: rx low for 3 clk then high -> FSM returns to IDLE; count=0, interrupt=0, no error flags.
- Overrun (FIFO_DEPTH_BITS=3): send 9 frames 0x01..0x09, no reads -> count=8, full=1, overrun=1. Pops return 0x01..0x08 in order.
- Parity (PARITY=2, DATA_BITS=7): send 0x35 with correct even parity -> stored. Send 0x35 with inverted parity bit -> parity_error=1, count unchanged.
- Framing and break: frame 0xA5 with stop bit forced 0, rx held low 40 clk -> framing_error=1, nothing pushed. After rx returns high, 0x3C is received correctly.
- Boundary: FIFO full, read asserted on the push cycle of 0x77 -> overrun=0, count stays 8, 0x77 is last out. Mid-frame nreset pulse -> all outputs at reset values, next frame received correctly.
